cache_mem_responder: RTL

CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

---
 rtl/cache_mem_pkg.sv | 16 +
 rtl/cache_mem_array.sv | 24 ++
 rtl/cache_mem_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache-side memory responder.
package cache_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Word-index width for the default 32768-word backing store (req_addr[16:2]).
  localparam int unsigned WORD_IDX_W = 15;

endpackage

// File: rtl/cache_mem_array.sv
// Single-port word store: synchronous write, combinational read, zero at time 0.
module cache_mem_array
  import cache_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32768,
  parameter int unsigned IDX_W       = WORD_IDX_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  // Contents are deliberately untouched by reset; unwritten words read as 0.
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/cache_mem_responder.sv
// Fixed-latency memory responder for a cache, one outstanding request at a time.
// Optional address range checking: define CACHE_MEM_RANGE_CHECK_EN.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32768,
  parameter int unsigned LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q;
  logic             cap_op, cap_oor;
  logic [IDX_W-1:0] cap_idx;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic             accept, req_oor, mem_we, sel_op, sel_oor;
  logic [IDX_W-1:0] req_idx, mem_idx;
  logic [31:0]      mem_rdata;
  logic             unused_addr_bits;

  assign req_idx          = req_addr[IDX_W+1:2];
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:IDX_W+2]};

`ifdef CACHE_MEM_RANGE_CHECK_EN
  assign req_oor = {32'd0, req_addr} >= (64'(DEPTH_WORDS) * 64'd4);
`else
  assign req_oor = 1'b0;
`endif

  assign req_ready = (state_q == ST_IDLE) & ~rst;
  assign accept    = req_valid & req_ready;

  // The single array port serves the live request in IDLE (write commit and the
  // LATENCY=1 read) and the captured address otherwise.
  assign mem_idx = (state_q == ST_IDLE) ? req_idx : cap_idx;
  assign sel_op  = (state_q == ST_IDLE) ? req_op  : cap_op;
  assign sel_oor = (state_q == ST_IDLE) ? req_oor : cap_oor;
  assign mem_we  = accept & (req_op == OP_WRITE) & ~req_oor;

  cache_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_idx),
    .wdata (req_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      cap_op  <= OP_READ;
      cap_oor <= 1'b0;
      cap_idx <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= 4'(LATENCY - 1);
        cap_op  <= req_op;
        cap_oor <= req_oor;
        cap_idx <= req_idx;
      end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state_q != ST_RESP && state_d == ST_RESP) begin
        rdata_q <= (sel_op == OP_READ && !sel_oor) ? mem_rdata : '0;
        err_q   <= sel_oor;
      end
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
